// File: rtl/counter_sequencer.sv
// Period timer: clears an external counter, then runs it for N periods of P cycles, ticking at each period end.
// Accept at edge k -> CLEAR k+1, RUN k+2; cmd_ready only in IDLE, so commands wait out CLEAR/RUN/DONE.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_period,
  input  logic [RPT_W-1:0] i_cmd_repeat,
  input  logic             i_stop,
  input  logic [WIDTH-1:0] i_cnt_val,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic             o_tick,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_busy,
  output logic [RPT_W-1:0] o_tick_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pm1;
  logic [RPT_W-1:0] r_rpt;
  logic [RPT_W-1:0] r_tick_count;
  logic             r_aborted;

  logic             w_idle;
  logic             w_accept;
  logic [WIDTH-1:0] w_cmd_pm1;
  logic [RPT_W-1:0] w_tc_inc;
  logic             w_hit;
  logic             w_final;

  // Storing P-1 lets P=0 wrap to all-ones, giving a full 2^WIDTH-cycle period.
  assign w_cmd_pm1 = i_cmd_period - WIDTH'(1);
  assign w_tc_inc  = r_tick_count + RPT_W'(1);

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = i_cmd_valid && o_cmd_ready;
  assign w_hit    = (r_state == S_RUN) && (i_cnt_val == r_pm1);
  assign w_final  = w_hit && (r_rpt != '0) && (w_tc_inc == r_rpt);

  assign o_cmd_ready  = w_idle && !i_reset;
  assign o_cnt_en     = (r_state == S_RUN);
  assign o_cnt_clr    = (r_state == S_CLEAR) || w_hit;
  assign o_tick       = w_hit;
  assign o_done       = (r_state == S_DONE);
  assign o_aborted    = (r_state == S_DONE) && r_aborted;
  assign o_busy       = !w_idle;
  assign o_tick_count = r_tick_count;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_pm1        <= '0;
      r_rpt        <= '0;
      r_tick_count <= '0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pm1        <= w_cmd_pm1;
            r_rpt        <= i_cmd_repeat;
            r_tick_count <= '0;
            r_aborted    <= 1'b0;
            r_state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (i_stop) begin
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_hit) begin
            r_tick_count <= w_tc_inc;
          end
          // A stop landing on the final tick still counts as a normal completion.
          if (w_final) begin
            r_aborted <= 1'b0;
            r_state   <= S_DONE;
          end else if (i_stop) begin
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural enable/sync-clear counter in the loop.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_period = 8'd0;
  logic [3:0] cmd_repeat = 4'd0;
  logic       stop = 1'b0;
  logic [7:0] cnt = 8'd77;
  logic       cnt_en, cnt_clr, tick, done, aborted, busy;
  logic [3:0] tick_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // External counter: clear wins over enable, not touched by reset.
  always @(posedge clk) begin
    if (cnt_clr) cnt <= 8'd0;
    else if (cnt_en) cnt <= cnt + 8'd1;
  end

  counter_sequencer #(.WIDTH(8), .RPT_W(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_period(cmd_period), .i_cmd_repeat(cmd_repeat), .i_stop(stop), .i_cnt_val(cnt),
    .o_cnt_en(cnt_en), .o_cnt_clr(cnt_clr), .o_tick(tick), .o_done(done),
    .o_aborted(aborted), .o_busy(busy), .o_tick_count(tick_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents a command in the current IDLE cycle (cycle 0); returns in cycle 1.
  task automatic send_cmd(input logic [7:0] p, input logic [3:0] n);
    cmd_period = p;
    cmd_repeat = n;
    cmd_valid  = 1'b1;
    step();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    checks++;
    if ({busy, cnt_en, cnt_clr, tick, done, aborted, cmd_ready} !== 7'b0)
      $display("FAIL reset_outputs got %b exp 0000000", {busy, cnt_en, cnt_clr, tick, done, aborted, cmd_ready});
    else passed++;
    checks++;
    if (tick_count !== 4'd0) $display("FAIL reset_tick_count got %0d exp 0", tick_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    step();
    checks++;
    if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_release_ready_busy got %b exp 10", {cmd_ready, busy});
    else passed++;
  endtask

  task automatic test_basic;
    logic [31:0] tmask = 0;
    logic [31:0] dmask = 0;
    logic        ab = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL basic_ready got %b exp 1", cmd_ready);
    else passed++;
    send_cmd(8'd4, 4'd3);
    checks++;
    if ({cnt_clr, cnt_en, busy} !== 3'b101) $display("FAIL basic_clear_cycle got %b exp 101", {cnt_clr, cnt_en, busy});
    else passed++;
    for (int c = 1; c <= 16; c++) begin
      if (tick) tmask[c] = 1'b1;
      if (done) begin dmask[c] = 1'b1; ab = aborted; end
      if (c == 15) begin
        checks++;
        if (busy !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy);
        else passed++;
      end
      step();
    end
    checks++;
    if (tmask !== 32'h0000_2220) $display("FAIL basic_ticks got %h exp 00002220", tmask);
    else passed++;
    checks++;
    if (dmask !== 32'h0000_4000) $display("FAIL basic_done got %h exp 00004000", dmask);
    else passed++;
    checks++;
    if (ab !== 1'b0) $display("FAIL basic_aborted got %b exp 0", ab);
    else passed++;
    checks++;
    if (tick_count !== 4'd3) $display("FAIL basic_tick_count got %0d exp 3", tick_count);
    else passed++;
  endtask

  task automatic test_period_max;
    int first_tick = -1;
    int ntick = 0;
    int done_cyc = -1;
    logic [7:0] val_at_tick = 8'd0;
    send_cmd(8'd0, 4'd1);
    for (int c = 1; c <= 262; c++) begin
      if (tick) begin
        ntick++;
        if (first_tick < 0) begin first_tick = c; val_at_tick = cnt; end
      end
      if (done) done_cyc = c;
      step();
    end
    checks++;
    if (first_tick != 257 || ntick != 1) $display("FAIL pmax_tick got cycle %0d count %0d exp cycle 257 count 1", first_tick, ntick);
    else passed++;
    checks++;
    if (val_at_tick !== 8'd255) $display("FAIL pmax_cnt_at_tick got %0d exp 255", val_at_tick);
    else passed++;
    checks++;
    if (done_cyc != 258) $display("FAIL pmax_done got cycle %0d exp 258", done_cyc);
    else passed++;
  endtask

  task automatic test_period_one;
    logic [31:0] tmask = 0;
    logic [31:0] dmask = 0;
    logic        bad_val = 1'b0;
    send_cmd(8'd1, 4'd2);
    for (int c = 1; c <= 6; c++) begin
      if (tick) begin tmask[c] = 1'b1; if (cnt !== 8'd0) bad_val = 1'b1; end
      if (done) dmask[c] = 1'b1;
      step();
    end
    checks++;
    if (tmask !== 32'h0000_000C) $display("FAIL p1_ticks got %h exp 0000000c", tmask);
    else passed++;
    checks++;
    if (bad_val !== 1'b0) $display("FAIL p1_cnt_at_tick got nonzero exp 0");
    else passed++;
    checks++;
    if (dmask !== 32'h0000_0010) $display("FAIL p1_done got %h exp 00000010", dmask);
    else passed++;
  endtask

  task automatic test_stop_abort;
    logic [31:0] tmask = 0;
    logic [31:0] dmask = 0;
    logic        ab = 1'b0;
    send_cmd(8'd5, 4'd0);
    for (int c = 1; c <= 14; c++) begin
      stop = (c == 9);
      if (tick) tmask[c] = 1'b1;
      if (done) begin dmask[c] = 1'b1; ab = aborted; end
      step();
    end
    stop = 1'b0;
    checks++;
    if (tmask !== 32'h0000_0040) $display("FAIL stop_ticks got %h exp 00000040", tmask);
    else passed++;
    checks++;
    if (dmask !== 32'h0000_0400 || ab !== 1'b1) $display("FAIL stop_done got mask %h aborted %b exp mask 00000400 aborted 1", dmask, ab);
    else passed++;
    checks++;
    if (tick_count !== 4'd1) $display("FAIL stop_tick_count got %0d exp 1", tick_count);
    else passed++;
  endtask

  task automatic test_stop_final;
    logic [31:0] tmask = 0;
    logic [31:0] dmask = 0;
    logic        ab = 1'b1;
    send_cmd(8'd3, 4'd2);
    for (int c = 1; c <= 10; c++) begin
      stop = (c == 7);
      if (tick) tmask[c] = 1'b1;
      if (done) begin dmask[c] = 1'b1; ab = aborted; end
      step();
    end
    stop = 1'b0;
    checks++;
    if (tmask !== 32'h0000_0090) $display("FAIL stopfinal_ticks got %h exp 00000090", tmask);
    else passed++;
    checks++;
    if (dmask !== 32'h0000_0100 || ab !== 1'b0) $display("FAIL stopfinal_done got mask %h aborted %b exp mask 00000100 aborted 0", dmask, ab);
    else passed++;
  endtask

  task automatic test_stop_clear;
    logic [31:0] tmask = 0;
    logic [31:0] dmask = 0;
    logic        ab = 1'b0;
    send_cmd(8'd4, 4'd1);
    for (int c = 1; c <= 5; c++) begin
      stop = (c == 1);
      if (tick) tmask[c] = 1'b1;
      if (done) begin dmask[c] = 1'b1; ab = aborted; end
      step();
    end
    stop = 1'b0;
    checks++;
    if (tmask !== 32'h0 || dmask !== 32'h0000_0004 || ab !== 1'b1)
      $display("FAIL stopclear got ticks %h done %h aborted %b exp ticks 00000000 done 00000004 aborted 1", tmask, dmask, ab);
    else passed++;
    checks++;
    if (tick_count !== 4'd0) $display("FAIL stopclear_tick_count got %0d exp 0", tick_count);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rmask = 0;
    logic [31:0] tmask = 0;
    logic [31:0] dmask = 0;
    logic        ab_any = 1'b0;
    logic [3:0]  tc_first = 4'd0;
    logic [3:0]  tc_new = 4'd15;
    send_cmd(8'd4, 4'd2);
    for (int c = 1; c <= 18; c++) begin
      if (c == 1) begin cmd_period = 8'd2; cmd_repeat = 4'd1; cmd_valid = 1'b1; end
      if (c == 12) cmd_valid = 1'b0;
      if (cmd_ready) rmask[c] = 1'b1;
      if (tick) tmask[c] = 1'b1;
      if (done) begin dmask[c] = 1'b1; ab_any = ab_any | aborted; end
      if (c == 10) tc_first = tick_count;
      if (c == 12) tc_new = tick_count;
      step();
    end
    checks++;
    if (rmask !== 32'h0007_0800) $display("FAIL b2b_ready got %h exp 00070800", rmask);
    else passed++;
    checks++;
    if (tmask !== 32'h0000_4220) $display("FAIL b2b_ticks got %h exp 00004220", tmask);
    else passed++;
    checks++;
    if (dmask !== 32'h0000_8400 || ab_any !== 1'b0) $display("FAIL b2b_done got %h aborted %b exp 00008400 aborted 0", dmask, ab_any);
    else passed++;
    checks++;
    if (tc_first !== 4'd2 || tc_new !== 4'd0) $display("FAIL b2b_tick_count got %0d then %0d exp 2 then 0", tc_first, tc_new);
    else passed++;
    checks++;
    if (tick_count !== 4'd1) $display("FAIL b2b_final_tick_count got %0d exp 1", tick_count);
    else passed++;
  endtask

  task automatic test_reset_midrun;
    logic bad = 1'b0;
    send_cmd(8'd10, 4'd3);
    for (int c = 1; c <= 6; c++) step();
    checks++;
    if ({busy, cnt_en} !== 2'b11) $display("FAIL midrun_running got %b exp 11", {busy, cnt_en});
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, cnt_en, cnt_clr, tick, done, aborted, cmd_ready} !== 7'b0)
      $display("FAIL midrun_reset_outputs got %b exp 0000000", {busy, cnt_en, cnt_clr, tick, done, aborted, cmd_ready});
    else passed++;
    checks++;
    if (tick_count !== 4'd0) $display("FAIL midrun_reset_tick_count got %0d exp 0", tick_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (cmd_ready !== 1'b1 || tick !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) $display("FAIL midrun_after_release got bad=%b exp 0", bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period_max();
    test_period_one();
    test_stop_abort();
    test_stop_final();
    test_stop_clear();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
